// File: rtl/rst_seq.sv
// Power-on reset sequencer: qualifies PLL lock, then releases system, SDRAM and
// CPU resets in order, with an SDRAM init timeout that retries from IDLE.
`timescale 1ns/1ps
module rst_seq #(
    parameter int LOCK_STABLE  = 1024,
    parameter int SDRAM_DELAY  = 20000,
    parameter int INIT_TIMEOUT = 65536,
    parameter int CPU_DELAY    = 16
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       sdram_init_done,
    output logic       sys_rst,
    output logic       sdram_rst,
    output logic       cpu_rst,
    output logic       ready,
    output logic [3:0] err_cnt
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        STABLE     = 3'd1,
        SYS_DLY    = 3'd2,
        SDRAM_INIT = 3'd3,
        CPU_DLY    = 3'd4,
        RUN        = 3'd5
    } state_t;

    localparam logic [16:0] STABLE_END  = 17'(LOCK_STABLE - 1);
    localparam logic [16:0] SYS_END     = 17'(SDRAM_DELAY - 1);
    localparam logic [16:0] TIMEOUT_END = 17'(INIT_TIMEOUT - 1);
    localparam logic [16:0] CPU_END     = 17'(CPU_DELAY - 1);

    state_t      state;
    state_t      next;
    logic [16:0] cnt;
    logic        sync_p0;
    logic        locked_s;
    logic        timeout;
    logic        timed;
    logic        sys_d;
    logic        sdram_d;
    logic        cpu_d;
    logic        ready_d;

    // pll_locked is asynchronous; only this synchronizer may look at it
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_p0  <= pll_locked;
            locked_s <= sync_p0;
        end
    end

    // State, shared counter, error count and registered output decode
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            err_cnt   <= '0;
            sys_rst   <= 1'b1;
            sdram_rst <= 1'b1;
            cpu_rst   <= 1'b1;
            ready     <= 1'b0;
        end else begin
            state <= next;
            if (next != state)
                cnt <= '0;
            else if (timed)
                cnt <= cnt + 17'd1;
            if (timeout && err_cnt != 4'd15)
                err_cnt <= err_cnt + 4'd1;
            sys_rst   <= sys_d;
            sdram_rst <= sdram_d;
            cpu_rst   <= cpu_d;
            ready     <= ready_d;
        end
    end

    always_comb begin
        next    = state;
        timeout = 1'b0;
        timed   = 1'b0;
        case (state)
            IDLE: begin
                if (locked_s)
                    next = STABLE;
            end
            STABLE: begin
                timed = 1'b1;
                if (cnt == STABLE_END)
                    next = SYS_DLY;
            end
            SYS_DLY: begin
                timed = 1'b1;
                if (cnt == SYS_END)
                    next = SDRAM_INIT;
            end
            SDRAM_INIT: begin
                timed = 1'b1;
                // init_done takes priority over a coincident timeout
                if (sdram_init_done) begin
                    next = CPU_DLY;
                end else if (cnt == TIMEOUT_END) begin
                    next    = IDLE;
                    timeout = 1'b1;
                end
            end
            CPU_DLY: begin
                timed = 1'b1;
                if (cnt == CPU_END)
                    next = RUN;
            end
            RUN: begin
                next = RUN;
            end
            default: begin
                next = IDLE;
            end
        endcase
        // Lock loss beats every other transition, including a pending timeout
        if (state != IDLE && !locked_s) begin
            next    = IDLE;
            timeout = 1'b0;
        end
    end

    always_comb begin
        sys_d   = 1'b1;
        sdram_d = 1'b1;
        cpu_d   = 1'b1;
        ready_d = 1'b0;
        case (next)
            SYS_DLY: begin
                sys_d = 1'b0;
            end
            SDRAM_INIT, CPU_DLY: begin
                sys_d   = 1'b0;
                sdram_d = 1'b0;
            end
            RUN: begin
                sys_d   = 1'b0;
                sdram_d = 1'b0;
                cpu_d   = 1'b0;
                ready_d = 1'b1;
            end
            default: begin
                sys_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: expectations are queued as each step is driven
// and popped/compared once the DUT has had the stated number of clock edges.
`timescale 1ns/1ps
module tb_rst_seq;

    logic       sys_clk;
    logic       rst_n;
    logic       pll_locked;
    logic       sdram_init_done;
    logic       sys_rst;
    logic       sdram_rst;
    logic       cpu_rst;
    logic       ready;
    logic [3:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];

    rst_seq #(
        .LOCK_STABLE (8),
        .SDRAM_DELAY (16),
        .INIT_TIMEOUT(64),
        .CPU_DELAY   (4)
    ) dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .pll_locked     (pll_locked),
        .sdram_init_done(sdram_init_done),
        .sys_rst        (sys_rst),
        .sdram_rst      (sdram_rst),
        .cpu_rst        (cpu_rst),
        .ready          (ready),
        .err_cnt        (err_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200us;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Queue the expected outputs, let n edges pass, then compare the oldest entry
    task automatic chk(input int n, input string tag, input logic s, input logic sd,
                       input logic c, input logic r, input logic [3:0] e);
        exp_t x;
        exp_t got;
        logic [7:0] obs;
        x.tag = tag;
        x.val = {s, sd, c, r, e};
        sb.push_back(x);
        if (n > 0)
            step(n);
        obs = {sys_rst, sdram_rst, cpu_rst, ready, err_cnt};
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            got = sb.pop_front();
            assert (obs === got.val)
            else begin
                failures++;
                $error("FAIL %s observed sys/sdram/cpu/rdy/err=%b required=%b",
                       got.tag, obs, got.val);
            end
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        pll_locked      = 1'b0;
        sdram_init_done = 1'b0;

        chk(2, "reset_state", 1, 1, 1, 0, 4'd0);

        // Nominal bring-up: two sync edges, 8 qualify, 16 SDRAM delay
        rst_n      = 1'b1;
        pll_locked = 1'b1;
        chk(10, "lock_qual_hold", 1, 1, 1, 0, 4'd0);
        chk(1,  "sys_release",    0, 1, 1, 0, 4'd0);
        chk(15, "sdram_hold",     0, 1, 1, 0, 4'd0);
        chk(1,  "sdram_release",  0, 0, 1, 0, 4'd0);
        chk(9,  "init_wait",      0, 0, 1, 0, 4'd0);
        sdram_init_done = 1'b1;
        chk(4,  "cpu_hold",       0, 0, 1, 0, 4'd0);
        chk(1,  "run",            0, 0, 0, 1, 4'd0);

        // Lock loss in RUN, then full relock
        pll_locked      = 1'b0;
        sdram_init_done = 1'b0;
        chk(2,  "run_before_loss", 0, 0, 0, 1, 4'd0);
        chk(1,  "lock_loss",       1, 1, 1, 0, 4'd0);
        pll_locked = 1'b1;
        chk(10, "relock_hold",     1, 1, 1, 0, 4'd0);
        chk(1,  "relock_sys",      0, 1, 1, 0, 4'd0);
        chk(16, "relock_sdram",    0, 0, 1, 0, 4'd0);
        sdram_init_done = 1'b1;
        chk(4,  "relock_cpu_hold", 0, 0, 1, 0, 4'd0);
        chk(1,  "relock_run",      0, 0, 0, 1, 4'd0);

        // One-cycle lock glitch at STABLE count 5 restarts qualification
        pll_locked      = 1'b0;
        sdram_init_done = 1'b0;
        chk(3,  "glitch_prep_idle", 1, 1, 1, 0, 4'd0);
        pll_locked = 1'b1;
        chk(6,  "stable_early",     1, 1, 1, 0, 4'd0);
        pll_locked = 1'b0;
        chk(1,  "glitch_low",       1, 1, 1, 0, 4'd0);
        pll_locked = 1'b1;
        chk(2,  "glitch_idle",      1, 1, 1, 0, 4'd0);
        chk(8,  "glitch_requal",    1, 1, 1, 0, 4'd0);
        chk(1,  "glitch_sys",       0, 1, 1, 0, 4'd0);

        // Init timeout after 64 SDRAM_INIT cycles
        chk(16, "init_enter",       0, 0, 1, 0, 4'd0);
        chk(63, "init_last",        0, 0, 1, 0, 4'd0);
        chk(1,  "timeout1",         1, 1, 1, 0, 4'd1);

        // init_done arriving on count 63 beats the timeout
        chk(88, "collide_pre",      0, 0, 1, 0, 4'd1);
        sdram_init_done = 1'b1;
        chk(1,  "collide",          0, 0, 1, 0, 4'd1);
        chk(3,  "collide_cpu_hold", 0, 0, 1, 0, 4'd1);
        chk(1,  "collide_run",      0, 0, 0, 1, 4'd1);

        pll_locked      = 1'b0;
        sdram_init_done = 1'b0;
        chk(3,  "loss_keeps_err",   1, 1, 1, 0, 4'd1);
        pll_locked = 1'b1;
        chk(91, "timeout2",         1, 1, 1, 0, 4'd2);

        // Each retry loop is 1 IDLE + 8 + 16 + 64 cycles; count saturates at 15
        for (int k = 3; k <= 16; k++)
            chk(89, "timeout_sat", 1, 1, 1, 0, (k > 15) ? 4'd15 : 4'(k));

        // Async reset in the middle of CPU_DLY, off the clock edge
        sdram_init_done = 1'b1;
        chk(26, "cpu_dly_mid",      0, 0, 1, 0, 4'd15);
        #2;
        rst_n = 1'b0;
        #1;
        chk(0,  "async_reset",      1, 1, 1, 0, 4'd0);
        chk(2,  "reset_held",       1, 1, 1, 0, 4'd0);
        sdram_init_done = 1'b0;
        rst_n = 1'b1;
        chk(10, "post_reset_hold",  1, 1, 1, 0, 4'd0);
        chk(1,  "post_reset_sys",   0, 1, 1, 0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
